// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared state type, default widths and control bit indices for the PWM generator
package pwm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwm_state_e;

  localparam int DEF_CNT_WIDTH = 16;
  localparam int DEF_PRE_WIDTH = 8;

  localparam int REG_EN_BIT  = 0;
  localparam int REG_INV_BIT = 1;

endpackage

// File: rtl/pwm_prescaler.sv
// rtl/pwm_prescaler.sv - clock divider producing one tick every pre_sh+1 clocks
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PRE_WIDTH = DEF_PRE_WIDTH
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 clear,
  input  logic [PRE_WIDTH-1:0] pre_sh,
  output logic                 tick
);

  logic [PRE_WIDTH-1:0] pre_cnt;

  // Tick is combinational so pre_sh=0 yields a tick on every clock.
  assign tick = !clear && (pre_cnt == pre_sh);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pre_cnt <= '0;
    end else if (clear || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pwm_gen_core.sv
// rtl/pwm_gen_core.sv - PWM generator: run FSM, shadowed settings, period counter and output compare
module pwm_gen_core
  import pwm_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int PRE_WIDTH = DEF_PRE_WIDTH
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 ctrl_enable,
  input  logic                 ctrl_invert,
  input  logic [CNT_WIDTH-1:0] period_in,
  input  logic [CNT_WIDTH-1:0] duty_in,
  input  logic [PRE_WIDTH-1:0] prescale_in,
  input  logic                 update_req,
  output logic                 pwm_out,
  output logic                 period_tick,
  output logic                 update_pending,
  output logic                 running
);

  logic [1:0] ctrl;
  assign ctrl[REG_EN_BIT]  = ctrl_enable;
  assign ctrl[REG_INV_BIT] = ctrl_invert;

  pwm_state_e state_q, state_d;
  logic       load_sh;
  logic       go;

  logic [CNT_WIDTH-1:0] period_sh, duty_sh, cnt_q;
  logic [PRE_WIDTH-1:0] pre_sh;
  logic                 inv_sh;
  logic                 pending_q;
  logic                 tick, wrap, reload;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Dropping enable stops the waveform at the next edge, not at period end.
  always_comb begin
    state_d = state_q;
    load_sh = 1'b0;
    go      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl[REG_EN_BIT]) begin
          state_d = RUN;
          load_sh = 1'b1;
        end
      end
      RUN: begin
        if (ctrl[REG_EN_BIT]) begin
          go = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  pwm_prescaler #(
    .PRE_WIDTH(PRE_WIDTH)
  ) u_prescaler (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .clear   (!go),
    .pre_sh  (pre_sh),
    .tick    (tick)
  );

  assign wrap   = tick && (cnt_q == period_sh);
  // A write landing on the wrap itself is taken immediately, never staged.
  assign reload = load_sh || (wrap && (pending_q || update_req));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      period_sh <= '0;
      duty_sh   <= '0;
      pre_sh    <= '0;
      inv_sh    <= 1'b0;
    end else if (reload) begin
      period_sh <= period_in;
      duty_sh   <= duty_in;
      pre_sh    <= prescale_in;
      inv_sh    <= ctrl[REG_INV_BIT];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pending_q <= 1'b0;
    end else if (!go || wrap) begin
      pending_q <= 1'b0;
    end else if (update_req) begin
      pending_q <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt_q <= '0;
    end else if (!go) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= wrap ? '0 : cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pwm_out     <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      period_tick <= wrap;
      pwm_out     <= go ? ((cnt_q < duty_sh) ^ inv_sh) : ctrl[REG_INV_BIT];
    end
  end

  assign update_pending = pending_q;
  assign running        = (state_q == RUN);

endmodule

// File: tb/tb_pwm_gen_core.sv
// tb/tb_pwm_gen_core.sv - directed bench with a clock-position reference model for pwm_gen_core
module tb_pwm_gen_core;

  logic        tb_ACLK    = 1'b0;
  logic        tb_ARESETN = 1'b0;
  logic        ctrl_enable = 1'b0;
  logic        ctrl_invert = 1'b0;
  logic [15:0] period_in   = '0;
  logic [15:0] duty_in     = '0;
  logic [7:0]  prescale_in = '0;
  logic        update_req  = 1'b0;
  logic        pwm_out, period_tick, update_pending, running;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  pwm_gen_core #(
    .CNT_WIDTH(16),
    .PRE_WIDTH(8)
  ) dut (
    .ACLK           (tb_ACLK),
    .ARESETN        (tb_ARESETN),
    .ctrl_enable    (ctrl_enable),
    .ctrl_invert    (ctrl_invert),
    .period_in      (period_in),
    .duty_in        (duty_in),
    .prescale_in    (prescale_in),
    .update_req     (update_req),
    .pwm_out        (pwm_out),
    .period_tick    (period_tick),
    .update_pending (update_pending),
    .running        (running)
  );

  always #5 tb_ACLK = ~tb_ACLK;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the clock position inside the current period,
  // the output level is (position / clocks_per_tick) < duty, shown one clock later.
  int m_run = 0, m_per = 0, m_duty = 0, m_pre = 0, m_inv = 0, m_pend = 0, m_pos = 0;
  int exp_pwm = 0, exp_tick = 0, m_tl = 1, m_len = 1;

  always @(posedge tb_ACLK or negedge tb_ARESETN) begin
    if (!tb_ARESETN) begin
      m_run = 0; m_per = 0; m_duty = 0; m_pre = 0; m_inv = 0; m_pend = 0; m_pos = 0;
      exp_pwm = 0; exp_tick = 0;
    end else if (m_run == 0) begin
      exp_pwm  = int'(ctrl_invert);
      exp_tick = 0;
      m_pend   = 0;
      if (ctrl_enable) begin
        m_run = 1; m_per = int'(period_in); m_duty = int'(duty_in);
        m_pre = int'(prescale_in); m_inv = int'(ctrl_invert); m_pos = 0;
      end
    end else if (!ctrl_enable) begin
      m_run = 0; m_pend = 0; exp_tick = 0;
      exp_pwm = int'(ctrl_invert);
    end else begin
      m_tl    = m_pre + 1;
      m_len   = (m_per + 1) * m_tl;
      exp_pwm = (((m_pos / m_tl) < m_duty) ? 1 : 0) ^ m_inv;
      if (m_pos == m_len - 1) begin
        exp_tick = 1;
        m_pos    = 0;
        if (m_pend != 0 || update_req) begin
          m_per = int'(period_in); m_duty = int'(duty_in);
          m_pre = int'(prescale_in); m_inv = int'(ctrl_invert);
        end
        m_pend = 0;
      end else begin
        exp_tick = 0;
        m_pos++;
        if (update_req) m_pend = 1;
      end
    end
  end

  always @(negedge tb_ACLK) begin
    if (chk_en) begin
      check("model_pwm_out", int'(pwm_out), exp_pwm);
      check("model_period_tick", int'(period_tick), exp_tick);
      check("model_running", int'(running), m_run);
      check("model_update_pending", int'(update_pending), m_pend);
    end
  end

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge tb_ACLK);
      n++;
    end while (period_tick !== 1'b1 && n < 300);
    if (period_tick !== 1'b1) check("tick_timeout", 0, 1);
  endtask

  task automatic count_period(output int clks, output int highs);
    clks  = 0;
    highs = 0;
    do begin
      @(negedge tb_ACLK);
      clks++;
      highs += int'(pwm_out);
    end while (period_tick !== 1'b1 && clks < 300);
  endtask

  task automatic measure(input string name, input int exp_clks, input int exp_high);
    int c, h;
    wait_tick();
    count_period(c, h);
    check({name, "_period_clks"}, c, exp_clks);
    check({name, "_high_clks"}, h, exp_high);
  endtask

  task automatic apply(input int duty, input int pre, input bit inv);
    duty_in     = 16'(duty);
    prescale_in = 8'(pre);
    ctrl_invert = inv;
    update_req  = 1'b1;
    @(negedge tb_ACLK);
    update_req  = 1'b0;
  endtask

  initial begin
    int c, h, n;
    @(posedge tb_ACLK);
    chk_en = 1'b1;
    repeat (2) @(negedge tb_ACLK);
    check("reset_pwm_out", int'(pwm_out), 0);
    check("reset_period_tick", int'(period_tick), 0);
    check("reset_running", int'(running), 0);
    check("reset_update_pending", int'(update_pending), 0);
    tb_ARESETN = 1'b1;

    // update_req while idle must not leave anything staged
    update_req = 1'b1;
    @(negedge tb_ACLK);
    update_req = 1'b0;
    check("idle_update_ignored", int'(update_pending), 0);

    period_in = 16'd9; duty_in = 16'd3; prescale_in = 8'd0;
    ctrl_enable = 1'b1;
    measure("basic", 10, 3);

    duty_in = 16'd7;
    measure("no_update_hold", 10, 3);

    apply(3, 3, 1'b0);
    measure("prescale3", 40, 12);

    apply(0, 0, 1'b0);
    measure("duty0", 10, 0);
    apply(12, 0, 1'b0);
    measure("duty12", 10, 10);
    apply(3, 0, 1'b1);
    measure("inv_duty3", 10, 7);
    apply(0, 0, 1'b1);
    measure("inv_duty0", 10, 10);
    apply(12, 0, 1'b1);
    measure("inv_duty12", 10, 0);
    apply(3, 0, 1'b0);
    measure("restore", 10, 3);

    @(negedge tb_ACLK);
    duty_in = 16'd5;
    update_req = 1'b1;
    @(negedge tb_ACLK);
    update_req = 1'b0;
    check("mid_update_pending", int'(update_pending), 1);
    measure("mid_update", 10, 5);

    repeat (9) @(negedge tb_ACLK);
    duty_in = 16'd2;
    update_req = 1'b1;
    @(negedge tb_ACLK);
    update_req = 1'b0;
    check("wrap_update_tick", int'(period_tick), 1);
    check("wrap_update_pending", int'(update_pending), 0);
    count_period(c, h);
    check("wrap_update_period_clks", c, 10);
    check("wrap_update_high_clks", h, 2);

    @(negedge tb_ACLK);
    check("stop_pre_high", int'(pwm_out), 1);
    ctrl_enable = 1'b0;
    n = 0;
    do begin
      @(negedge tb_ACLK);
      n++;
    end while ((pwm_out !== 1'b0 || running !== 1'b0) && n < 5);
    check("stop_latency_ok", (n <= 2) ? 1 : 0, 1);

    duty_in = 16'd12;
    ctrl_enable = 1'b1;
    wait_tick();
    repeat (4) @(negedge tb_ACLK);
    check("pre_reset_pwm_out", int'(pwm_out), 1);
    check("pre_reset_running", int'(running), 1);
    #2;
    tb_ARESETN = 1'b0;
    #1;
    check("async_reset_pwm_out", int'(pwm_out), 0);
    check("async_reset_period_tick", int'(period_tick), 0);
    check("async_reset_running", int'(running), 0);
    check("async_reset_update_pending", int'(update_pending), 0);
    ctrl_enable = 1'b0;
    @(negedge tb_ACLK);
    tb_ARESETN = 1'b1;
    repeat (3) @(negedge tb_ACLK);
    check("post_reset_running", int'(running), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
